// File: rtl/clk_pkg.sv
// Shared clocking constants and helpers for the divider slice.
// Board and video rates live here so every consumer derives ratios the same way.
package clk_pkg;

    localparam longint unsigned NEXYS4_CLK_HZ = 100_000_000;
    localparam longint unsigned VGA_PIX_HZ    = 25_000_000;

    // How a channel behaves for a given active ratio.
    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_TICK = 2'd1,
        MODE_DIV  = 2'd2
    } chan_mode_e;

    // Nearest-integer divide ratio from source to destination frequency; 0 disables.
    function automatic int unsigned div_ratio(
        input longint unsigned src_hz,
        input longint unsigned dst_hz
    );
        longint unsigned q;
        if (dst_hz == 0) begin
            return 0;
        end
        q = (src_hz + (dst_hz >> 1)) / dst_hz;
        return 32'(q);
    endfunction

    function automatic chan_mode_e ratio_mode(input int unsigned n);
        if (n == 0) begin
            return MODE_OFF;
        end
        if (n == 1) begin
            return MODE_TICK;
        end
        return MODE_DIV;
    endfunction

    localparam int unsigned VGA_DIV = div_ratio(NEXYS4_CLK_HZ, VGA_PIX_HZ);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow ratio with boundary reload,
// and registered divided clock / clock-enable outputs.
module clk_div_chan
    import clk_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             div_load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             sync_restart,
    output logic             clk_out,
    output logic             ce_out,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEF_N   = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_CNT = (DEFAULT_DIV == 0) ? '0 : CNT_W'(DEFAULT_DIV - 1);

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] n_reg, n_next;
    logic [CNT_W-1:0] shadow_reg, shadow_next;
    logic             pending_reg, pending_next;
    logic             clk_reg, clk_next;
    logic             ce_reg, ce_next;

    logic             at_last;
    logic             wrap;
    logic [CNT_W-1:0] hi;

    always_comb begin
        shadow_next  = div_load ? div_in : shadow_reg;
        at_last      = (n_reg != '0) && (cnt_reg == (n_reg - CNT_W'(1)));
        // A disabled channel has no period boundary, so a load starts it at once.
        wrap         = sync_restart || at_last || ((n_reg == '0) && (div_load || pending_reg));
        n_next       = wrap ? shadow_next : n_reg;
        pending_next = wrap ? 1'b0 : (pending_reg | div_load);
        cnt_next     = (wrap || (n_reg == '0)) ? '0 : (cnt_reg + CNT_W'(1));
        hi           = n_next >> 1;

        clk_next = 1'b0;
        ce_next  = 1'b0;
        case (ratio_mode(32'(n_next)))
            MODE_TICK: begin
                ce_next = 1'b1;
            end
            MODE_DIV: begin
                clk_next = (cnt_next < hi);
                ce_next  = (cnt_next == '0);
            end
            default: begin
                clk_next = 1'b0;
                ce_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt_reg     <= DEF_CNT;
            n_reg       <= DEF_N;
            shadow_reg  <= DEF_N;
            pending_reg <= 1'b0;
            clk_reg     <= 1'b0;
            ce_reg      <= 1'b0;
        end else begin
            cnt_reg     <= cnt_next;
            n_reg       <= n_next;
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
            clk_reg     <= clk_next;
            ce_reg      <= ce_next;
        end
    end

    assign clk_out = clk_reg;
    assign ce_out  = ce_reg;
    assign pending = pending_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / clock-enable generator.
// Each channel takes its own slice of div_in and shares the restart strobe.
module clk_div_multi
    import clk_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = VGA_DIV
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       div_load,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    input  logic                    sync_restart,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       ce_out,
    output logic [NUM_CH-1:0]       pending
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_chan
            clk_div_chan #(
                .CNT_W       (CNT_W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_chan (
                .clk_in       (clk_in),
                .rst          (rst),
                .div_load     (div_load[gi]),
                .div_in       (div_in[gi*CNT_W +: CNT_W]),
                .sync_restart (sync_restart),
                .clk_out      (clk_out[gi]),
                .ce_out       (ce_out[gi]),
                .pending      (pending[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: directed scenarios plus random loads/restarts,
// checked every cycle against a period-level model of each channel.
module tb_clk_div_multi;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_DIV = 4;

    logic                    clk_in = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       div_load = '0;
    logic [NUM_CH*CNT_W-1:0] div_in = '0;
    logic                    sync_restart = 1'b0;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       ce_out;
    logic [NUM_CH-1:0]       pending;

    clk_div_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .div_load     (div_load),
        .div_in       (div_in),
        .sync_restart (sync_restart),
        .clk_out      (clk_out),
        .ce_out       (ce_out),
        .pending      (pending)
    );

    always #5 clk_in = ~clk_in;

    int    total = 0;
    int    bad   = 0;
    string phase = "init";

    // Model: each channel is a current period length, the age within that period,
    // the most recently written ratio, and whether that ratio still waits.
    int m_n   [NUM_CH];
    int m_age [NUM_CH];
    int m_sh  [NUM_CH];
    bit m_pend[NUM_CH];

    function automatic void model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            m_n[k]    = DEFAULT_DIV;
            m_sh[k]   = DEFAULT_DIV;
            m_pend[k] = 1'b0;
            m_age[k]  = (DEFAULT_DIV == 0) ? 0 : DEFAULT_DIV - 1;
        end
    endfunction

    function automatic void model_edge(input logic [NUM_CH-1:0] ld,
                                       input logic [NUM_CH*CNT_W-1:0] din,
                                       input logic rs);
        bit new_period;
        for (int k = 0; k < NUM_CH; k++) begin
            new_period = rs || (m_n[k] > 0 && m_age[k] == m_n[k] - 1)
                         || (m_n[k] == 0 && (ld[k] || m_pend[k]));
            if (ld[k]) m_sh[k] = int'(din[k*CNT_W +: CNT_W]);
            if (new_period) begin
                m_n[k]    = m_sh[k];
                m_age[k]  = 0;
                m_pend[k] = 1'b0;
            end else begin
                m_pend[k] = m_pend[k] | ld[k];
                if (m_n[k] > 0) m_age[k] = m_age[k] + 1;
            end
        end
    endfunction

    function automatic logic [NUM_CH-1:0] exp_clk();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k] = (m_n[k] >= 2) && (m_age[k] < m_n[k] / 2);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_ce();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k] = (m_n[k] >= 1) && (m_age[k] == 0);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_pend();
        logic [NUM_CH-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k] = m_pend[k];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [NUM_CH-1:0] obs, input logic [NUM_CH-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%b expected=%b", phase, tag, obs, exp);
        end
    endtask

    // One clock edge: inputs held across the edge, outputs sampled 1 ns later.
    task automatic tick();
        logic [NUM_CH-1:0]       ld;
        logic [NUM_CH*CNT_W-1:0] din;
        logic                    rs;
        ld  = div_load;
        din = div_in;
        rs  = sync_restart;
        @(posedge clk_in);
        #1;
        model_edge(ld, din, rs);
        chk("clk_out", clk_out, exp_clk());
        chk("ce_out", ce_out, exp_ce());
        chk("pending", pending, exp_pend());
        $display("t=%0t %s ld=%b rs=%b clk=%b ce=%b pend=%b", $time, phase, ld, rs, clk_out, ce_out, pending);
    endtask

    task automatic load(input int ch, input int val);
        div_load[ch] = 1'b1;
        div_in[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic clear_in();
        div_load     = '0;
        sync_restart = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [3:0]        pat;
        logic [NUM_CH-1:0] ones;
        logic              ready;
        pat  = 4'b0011;
        ones = '1;

        // Reset held over several edges
        phase = "reset";
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_clk", clk_out, '0);
        chk("rst_ce", ce_out, '0);
        chk("rst_pend", pending, '0);
        rst = 1'b0;

        // Defaults: 1,1,0,0 from the first edge, ce on edges 1,5,9
        phase = "default";
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("pat_clk", clk_out, pat[i % 4] ? ones : '0);
            chk("pat_ce", ce_out, (i % 4 == 0) ? ones : '0);
        end

        // Mid-period load of 5 on ch0
        phase = "load5";
        load(0, 5);
        tick();
        clear_in();
        chk("pend_set", pending, 2'b01);
        ticks(14);

        // ch1: N=1, then N=0, then reload 6
        phase = "ch1_n1";
        load(1, 1);
        tick();
        clear_in();
        ticks(8);
        phase = "ch1_n0";
        load(1, 0);
        tick();
        clear_in();
        ticks(5);
        phase = "ch1_n6";
        load(1, 6);
        tick();
        clear_in();
        chk("n6_start", {clk_out[1], ce_out[1]}, 2'b11);
        ticks(13);

        // Load coinciding with ch0's wrap, then back-to-back 7 then 3
        phase = "wrap_load";
        ready = 1'b0;
        for (int i = 0; i < 40 && !ready; i++) begin
            if (m_n[0] > 0 && m_age[0] == m_n[0] - 1) ready = 1'b1;
            else tick();
        end
        chk("wrap_wait", {1'b0, ready}, 2'b01);
        load(0, 7);
        tick();
        clear_in();
        chk("bypass_pend", {1'b0, pending[0]}, 2'b00);
        ticks(2);
        phase = "b2b";
        load(0, 7);
        tick();
        load(0, 3);
        tick();
        clear_in();
        ticks(12);

        // Out-of-phase ch0=4, ch1=6, then restart aligns them
        phase = "restart";
        load(0, 4);
        tick();
        clear_in();
        ticks(10);
        sync_restart = 1'b1;
        tick();
        clear_in();
        chk("rs_ce", ce_out, 2'b11);
        chk("rs_clk", clk_out, 2'b11);
        ticks(11);
        tick();
        chk("rs_ce12", ce_out, 2'b11);
        ticks(4);

        // Random loads and restarts
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 7) == 0) load(k, int'($urandom_range(0, 9)));
            end
            sync_restart = ($urandom_range(0, 39) == 0);
            tick();
            clear_in();
        end

        // Async reset while a load is pending at cnt=2
        phase = "rst_pend";
        load(0, 4);
        sync_restart = 1'b1;
        tick();
        clear_in();
        tick();
        load(0, 9);
        tick();
        clear_in();
        chk("pend_before_rst", {1'b0, pending[0]}, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_clk", clk_out, '0);
        chk("arst_ce", ce_out, '0);
        chk("arst_pend", pending, '0);
        @(posedge clk_in);
        #1;
        rst = 1'b0;
        model_reset();
        phase = "after_rst";
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("pat2_clk", clk_out, pat[i % 4] ? ones : '0);
            chk("pat2_ce", ce_out, (i % 4 == 0) ? ones : '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
